// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle RISC-V controller: state
// encoding, opcodes, ALU operation classes and the per-state control word.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for a state; anything not set stays zero.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.pcupdate  = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.aluop     = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMREAD: c.adrsrc = 1'b1;
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = 2'b10;
        c.aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: c.regwrite = 1'b1;
      S_BEQ: begin
        c.alusrca = 2'b10;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
      end
      S_JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: maps the FSM's aluop class plus instruction fields
// to the 3-bit alucontrol code.
module mc_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) can encode sub; addi with instr[30] set is still add.
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: registered Moore control word, write enables
// masked while reset is held, immsrc decoded from opcode in every state.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
  end

  // Control word is registered alongside the state so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // While reset is held the datapath sees FETCH decode with every write disabled.
  always_comb begin
    ctrl = ctrl_q;
    if (reset) begin
      ctrl          = state_ctrl(S_FETCH);
      ctrl.pcupdate = 1'b0;
      ctrl.branch   = 1'b0;
      ctrl.irwrite  = 1'b0;
      ctrl.regwrite = 1'b0;
      ctrl.memwrite = 1'b0;
    end
  end

  always_comb begin
    case (opcode)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  assign pcwrite   = ctrl.pcupdate | (ctrl.branch & zero);
  assign adrsrc    = ctrl.adrsrc;
  assign memwrite  = ctrl.memwrite;
  assign irwrite   = ctrl.irwrite;
  assign regwrite  = ctrl.regwrite;
  assign resultsrc = ctrl.resultsrc;
  assign alusrca   = ctrl.alusrca;
  assign alusrcb   = ctrl.alusrcb;
  assign state     = state_q;

  mc_alu_decoder u_alu_decoder (
    .aluop      (ctrl.aluop),
    .funct3     (funct3),
    .op5        (opcode[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table of instructions, hand-written reset
// sequences, and a random instruction stream checked against a reference model.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .immsrc     (immsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  int         n_cyc, n_rw, n_mw, n_pcw;
  logic [2:0] alu_c2;
  logic [1:0] imm_c0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [1:0] imm;
    logic [2:0] alu2;
    int         rw;
    int         mw;
    int         pcw;
  } vec_t;

  function automatic logic [15:0] observed();
    return {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
            alusrca, alusrcb, immsrc, alucontrol};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: state walk per instruction class
  function automatic void model_states(input logic [6:0] op);
    exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    if (op == OP_LW) begin
      exp_q.push_back(S_MEMADR); exp_q.push_back(S_MEMREAD); exp_q.push_back(S_MEMWB);
    end else if (op == OP_SW) begin
      exp_q.push_back(S_MEMADR); exp_q.push_back(S_MEMWRITE);
    end else if (op == OP_R) begin
      exp_q.push_back(S_EXECUTER); exp_q.push_back(S_ALUWB);
    end else if (op == OP_I) begin
      exp_q.push_back(S_EXECUTEI); exp_q.push_back(S_ALUWB);
    end else if (op == OP_BEQ) begin
      exp_q.push_back(S_BEQ);
    end else if (op == OP_JAL) begin
      exp_q.push_back(S_JAL); exp_q.push_back(S_ALUWB);
    end
  endfunction

  // Reference model: expected output bundle for a state and inputs
  function automatic logic [15:0] model_out(input state_t st, input logic [6:0] op,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z, input logic rst);
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; sa = 0; sb = 0; alu = 3'b000;
    imm = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
    if (rst) begin
      sb = 2'b10; rs = 2'b10;
    end else begin
      case (st)
        S_FETCH:    begin irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10; end
        S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
        S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
        S_MEMREAD:  adr = 1;
        S_MEMWB:    begin rs = 2'b01; rw = 1; end
        S_MEMWRITE: begin adr = 1; mw = 1; end
        S_EXECUTER, S_EXECUTEI: begin
          sa = 2'b10;
          sb = (st == S_EXECUTEI) ? 2'b01 : 2'b00;
          if (f3 == 3'b000)      alu = (op[5] && f7) ? 3'b001 : 3'b000;
          else if (f3 == 3'b010) alu = 3'b101;
          else if (f3 == 3'b110) alu = 3'b011;
          else if (f3 == 3'b111) alu = 3'b010;
        end
        S_ALUWB:    rw = 1;
        S_BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = z; end
        S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
        default:    ;
      endcase
    end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
  endfunction

  // Driver: run one instruction from FETCH, checking every cycle against the model
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input string tag);
    state_t st;
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    exp_q.delete();
    model_states(op);
    n_cyc = 0; n_rw = 0; n_mw = 0; n_pcw = 0; alu_c2 = 3'b000; imm_c0 = 2'b00;
    while (exp_q.size() > 0) begin
      st = state_t'(exp_q.pop_front());
      @(negedge clk);
      check({tag, "_state"}, 32'(state), 32'(st));
      check({tag, "_out"}, 32'(observed()), 32'(model_out(st, op, f3, f7, z, 1'b0)));
      n_rw  += int'(regwrite);
      n_mw  += int'(memwrite);
      n_pcw += int'(pcwrite);
      if (n_cyc == 0) imm_c0 = immsrc;
      if (n_cyc == 2) alu_c2 = alucontrol;
      n_cyc++;
      @(posedge clk); #1;
    end
    check({tag, "_end_fetch"}, 32'(state), 32'(S_FETCH));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("reset_out", 32'(observed()), 32'(model_out(S_FETCH, opcode, funct3, funct7b5, zero, 1'b1)));
    @(posedge clk); #1;
    check("reset_state", 32'(state), 32'(S_FETCH));
    reset = 1'b0;
  endtask

  // Assert reset after `steps` edges of instruction `op`, expecting DUT in `mid`.
  task automatic reset_mid(input logic [6:0] op, input int steps, input state_t mid, input string tag);
    opcode = op; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
    for (int i = 0; i < steps; i++) begin @(posedge clk); #1; end
    check({tag, "_pre"}, 32'(state), 32'(mid));
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_held_out"}, 32'(observed()), 32'(model_out(mid, op, 3'b000, 1'b0, 1'b1, 1'b1)));
    @(posedge clk); #1;
    check({tag, "_to_fetch"}, 32'(state), 32'(S_FETCH));
    @(negedge clk);
    check({tag, "_writes_off"}, 32'({pcwrite, irwrite, regwrite, memwrite}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check({tag, "_first_fetch"}, 32'({state, irwrite}), 32'({S_FETCH, 1'b1}));
    @(posedge clk); #1;
    check({tag, "_decode"}, 32'(state), 32'(S_DECODE));
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{OP_LW,  3'b010, 1'b0, 1'b0, 2'b00, 3'b000, 1, 0, 1};
    vecs[1]  = '{OP_SW,  3'b010, 1'b0, 1'b0, 2'b01, 3'b000, 0, 1, 1};
    vecs[2]  = '{OP_R,   3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1, 0, 1};
    vecs[3]  = '{OP_R,   3'b000, 1'b1, 1'b0, 2'b00, 3'b001, 1, 0, 1};
    vecs[4]  = '{OP_I,   3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 1, 0, 1};
    vecs[5]  = '{OP_R,   3'b010, 1'b0, 1'b0, 2'b00, 3'b101, 1, 0, 1};
    vecs[6]  = '{OP_R,   3'b110, 1'b0, 1'b0, 2'b00, 3'b011, 1, 0, 1};
    vecs[7]  = '{OP_I,   3'b111, 1'b0, 1'b0, 2'b00, 3'b010, 1, 0, 1};
    vecs[8]  = '{OP_R,   3'b001, 1'b1, 1'b0, 2'b00, 3'b000, 1, 0, 1};
    vecs[9]  = '{OP_BEQ, 3'b000, 1'b0, 1'b1, 2'b10, 3'b001, 0, 0, 2};
    vecs[10] = '{OP_BEQ, 3'b000, 1'b0, 1'b0, 2'b10, 3'b001, 0, 0, 1};
    vecs[11] = '{OP_JAL, 3'b000, 1'b0, 1'b0, 2'b11, 3'b000, 1, 0, 2};
    vecs[12] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 0, 0, 1};
    vecs[13] = '{7'b1111111, 3'b111, 1'b1, 1'b1, 2'b00, 3'b000, 0, 0, 1};

    opcode = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, tag);
      check({tag, "_regwrite_cycles"}, 32'(n_rw),  32'(vecs[i].rw));
      check({tag, "_memwrite_cycles"}, 32'(n_mw),  32'(vecs[i].mw));
      check({tag, "_pcwrite_cycles"},  32'(n_pcw), 32'(vecs[i].pcw));
      check({tag, "_immsrc"},          32'(imm_c0), 32'(vecs[i].imm));
      if (n_cyc > 2) check({tag, "_alu_cycle2"}, 32'(alu_c2), 32'(vecs[i].alu2));
    end

    reset_mid(OP_LW, 3, S_MEMREAD, "rst_memread");
    do_reset();
    reset_mid(OP_SW, 3, S_MEMWRITE, "rst_memwrite");
    do_reset();
    reset_mid(OP_R, 3, S_ALUWB, "rst_aluwb");
    do_reset();

    for (int i = 0; i < 200; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 7))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_I;
        4: op = OP_BEQ;
        5: op = OP_JAL;
        default: op = 7'($urandom_range(0, 127));
      endcase
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
